// File: rtl/cache_flush_unit_pkg.sv
// Shared cache definitions: flush FSM states, default geometry, line address builder.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cache_flush_unit_pkg;

    // Default cache geometry: 8 sets, 24-bit tag, 32-byte lines.
    localparam int S_INDEX_DEF  = 3;
    localparam int S_TAG_DEF    = 24;
    localparam int S_OFFSET_DEF = 5;
    localparam int S_LINE_DEF   = 256;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SCAN  = 3'd1,
        WB    = 3'd2,
        CLEAR = 3'd3,
        DONE  = 3'd4
    } flush_state_t;

    // Line-aligned address {tag, index, offset=0}. Operands arrive zero-extended
    // to 64 bits; the caller truncates the result to its own address width.
    function automatic logic [63:0] line_addr(input logic [63:0] tag,
                                              input logic [63:0] idx,
                                              input int          idx_w,
                                              input int          off_w);
        return (tag << (idx_w + off_w)) | (idx << off_w);
    endfunction

endpackage

// File: rtl/cache_flush_unit.sv
// Flush walker: scans every set, writes each valid+dirty line back to pmem, clears its dirty bit.
// Latency: 2**s_index SCAN cycles + 1 DONE cycle; each dirty line adds its WB wait + 1 CLEAR cycle.
// Backpressure: WB holds pmem_write/address/data stable until pmem_resp; no timeout.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start / busy / done    flush request, walk in progress, one-cycle completion pulse
//   wb_count               lines written back in the current/last flush
//   arr_read, arr_index    read strobe and set index shared by valid/dirty/tag/data arrays
//   valid_out..data_out    combinational array read data for arr_index
//   dirty_load/_datain     dirty bit clear (datain always 0)
//   valid_load/_datain     valid bit clear (datain always 0), only with CACHE_FLUSH_INVALIDATE_EN
//   pmem_*                 line write-back request/response
//
// Build option: define CACHE_FLUSH_INVALIDATE_EN to also clear the valid bit of every
// set (clean sets included), leaving the cache fully invalidated after the walk.
module cache_flush_unit
    import cache_flush_unit_pkg::*;
#(
    parameter int s_index  = S_INDEX_DEF,
    parameter int s_tag    = S_TAG_DEF,
    parameter int s_offset = S_OFFSET_DEF,
    parameter int s_line   = S_LINE_DEF
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    output logic                              busy,
    output logic                              done,
    output logic [s_index:0]                  wb_count,
    output logic                              arr_read,
    output logic [s_index-1:0]                arr_index,
    input  logic                              valid_out,
    input  logic                              dirty_out,
    input  logic [s_tag-1:0]                  tag_out,
    input  logic [s_line-1:0]                 data_out,
    output logic                              dirty_load,
    output logic                              dirty_datain,
    output logic                              valid_load,
    output logic                              valid_datain,
    output logic                              pmem_write,
    output logic [s_tag+s_index+s_offset-1:0] pmem_address,
    output logic [s_line-1:0]                 pmem_wdata,
    input  logic                              pmem_resp
);

    localparam int                 ADDR_W   = s_tag + s_index + s_offset;
    localparam logic [s_index-1:0] LAST_IDX = '1;

    flush_state_t       state;
    flush_state_t       state_nxt;
    logic [s_index-1:0] idx;
    logic               last_set;
    logic               line_hit;

    assign last_set  = (idx == LAST_IDX);
    assign line_hit  = valid_out & dirty_out;
    assign arr_index = idx;

    // Array writes only ever clear bits.
    assign dirty_datain = 1'b0;
    assign valid_datain = 1'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        done       = 1'b0;
        arr_read   = 1'b0;
        dirty_load = 1'b0;
        valid_load = 1'b0;
        pmem_write = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                busy     = 1'b1;
                arr_read = 1'b1;
                if (line_hit) begin
                    state_nxt = WB;
                end else begin
`ifdef CACHE_FLUSH_INVALIDATE_EN
                    // Clean sets still pass through CLEAR to drop their valid bit.
                    state_nxt = CLEAR;
`else
                    state_nxt = last_set ? DONE : SCAN;
`endif
                end
            end
            WB: begin
                busy       = 1'b1;
                pmem_write = 1'b1;
                if (pmem_resp) begin
                    state_nxt = CLEAR;
                end
            end
            CLEAR: begin
                busy       = 1'b1;
                dirty_load = 1'b1;
`ifdef CACHE_FLUSH_INVALIDATE_EN
                valid_load = 1'b1;
`endif
                state_nxt  = last_set ? DONE : SCAN;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Index counter, write-back counter and the latched line. The index advances
    // exactly when the FSM moves on to scan the next set, so the terminal compare
    // in SCAN/CLEAR is the only thing that stops the walk (no wrap).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx          <= '0;
            wb_count     <= '0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            if (state == IDLE && start) begin
                idx      <= '0;
                wb_count <= '0;
            end
            if ((state == SCAN && state_nxt == SCAN) ||
                (state == CLEAR && state_nxt == SCAN)) begin
                idx <= idx + 1'b1;
            end
            if (state == SCAN && state_nxt == WB) begin
                pmem_address <= ADDR_W'(line_addr(64'(tag_out), 64'(idx), s_index, s_offset));
                pmem_wdata   <= data_out;
            end
            if (state == WB && pmem_resp) begin
                wb_count <= wb_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cache_flush_unit.sv
module tb_cache_flush_unit;

    logic         clk;
    logic         rst;
    logic         start;
    logic         busy;
    logic         done;
    logic [3:0]   wb_count;
    logic         arr_read;
    logic [2:0]   arr_index;
    logic         valid_out;
    logic         dirty_out;
    logic [23:0]  tag_out;
    logic [255:0] data_out;
    logic         dirty_load;
    logic         dirty_datain;
    logic         valid_load;
    logic         valid_datain;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp;

    cache_flush_unit dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .wb_count     (wb_count),
        .arr_read     (arr_read),
        .arr_index    (arr_index),
        .valid_out    (valid_out),
        .dirty_out    (dirty_out),
        .tag_out      (tag_out),
        .data_out     (data_out),
        .dirty_load   (dirty_load),
        .dirty_datain (dirty_datain),
        .valid_load   (valid_load),
        .valid_datain (valid_datain),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- cache arrays model ----------------
    logic         vmem [8];
    logic         dmem [8];
    logic [23:0]  tmem [8];
    logic [255:0] lmem [8];
    logic [7:0]   pre_v, pre_d;
    logic         preload;
    logic         v_hold, d_hold;
    logic [23:0]  t_hold;
    logic [255:0] l_hold;

    assign valid_out = arr_read ? vmem[arr_index] : v_hold;
    assign dirty_out = arr_read ? dmem[arr_index] : d_hold;
    assign tag_out   = arr_read ? tmem[arr_index] : t_hold;
    assign data_out  = arr_read ? lmem[arr_index] : l_hold;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) begin
                vmem[i] <= pre_v[i];
                dmem[i] <= pre_d[i];
            end
        end else begin
            if (dirty_load) dmem[arr_index] <= dirty_datain;
            if (valid_load) vmem[arr_index] <= valid_datain;
        end
        if (arr_read) begin
            v_hold <= vmem[arr_index];
            d_hold <= dmem[arr_index];
            t_hold <= tmem[arr_index];
            l_hold <= lmem[arr_index];
        end
    end

    // ---------------- memory responder ----------------
    int           resp_delay;
    int           wcnt;
    logic         stab_err;
    logic [31:0]  got_addr [$];
    logic [255:0] got_data [$];

    initial begin
        pmem_resp = 1'b0;
        wcnt      = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pmem_resp = 1'b0;
                wcnt      = 0;
            end else if (pmem_resp) begin
                pmem_resp = 1'b0;
            end else if (pmem_write) begin
                wcnt++;
                if (wcnt == 1) begin
                    got_addr.push_back(pmem_address);
                    got_data.push_back(pmem_wdata);
                end else if (pmem_address != got_addr[$] || pmem_wdata != got_data[$]) begin
                    stab_err = 1'b1;
                end
                if (wcnt >= resp_delay) begin
                    pmem_resp = 1'b1;
                    wcnt      = 0;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload_arrays(input logic [7:0] v, input logic [7:0] d);
        pre_v = v;
        pre_d = d;
        @(negedge clk);
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    function automatic logic [7:0] pack_arr(input logic a [8]);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = a[i];
        return r;
    endfunction

    // One complete flush compared against a set-level reference model.
    task automatic run_flush(input string nm, input logic [7:0] v, input logic [7:0] d,
                             input int dly, input int exp_wb, input int restart_at);
        logic [31:0]  exp_addr [$];
        logic [255:0] exp_data [$];
        int           exp_busy, busy_cnt;
        logic [7:0]   exp_dl, exp_vl, exp_v_after, exp_d_after, dl, vl;
        logic         got_done;

        preload_arrays(v, d);
        for (int i = 0; i < 8; i++) begin
            if (v[i] && d[i]) begin
                exp_addr.push_back(32'(tmem[i]) * 32'd256 + 32'(i) * 32'd32);
                exp_data.push_back(lmem[i]);
            end
        end
`ifdef CACHE_FLUSH_INVALIDATE_EN
        exp_busy    = 16 + exp_addr.size() * dly;
        exp_dl      = 8'hFF;
        exp_vl      = 8'hFF;
        exp_v_after = 8'h00;
`else
        exp_busy    = 8 + exp_addr.size() * (dly + 1);
        exp_dl      = v & d;
        exp_vl      = 8'h00;
        exp_v_after = v;
`endif
        exp_d_after = d & ~(v & d);

        got_addr.delete();
        got_data.delete();
        stab_err   = 1'b0;
        resp_delay = dly;
        busy_cnt   = 0;
        dl         = '0;
        vl         = '0;
        got_done   = 1'b0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (busy) busy_cnt++;
            if (dirty_load) dl[arr_index] = 1'b1;
            if (valid_load) vl[arr_index] = 1'b1;
            start = (restart_at != 0 && busy_cnt == restart_at && busy) ? 1'b1 : 1'b0;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        // A start presented during DONE must be dropped.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;

        chk({nm, " done_seen"}, 64'(got_done), 64'd1);
        chk({nm, " busy_cycles"}, 64'(busy_cnt), 64'(exp_busy));
        chk({nm, " wb_count"}, 64'(wb_count), 64'(exp_wb));
        chk({nm, " write_count"}, 64'(got_addr.size()), 64'(exp_addr.size()));
        if (got_addr.size() == exp_addr.size()) begin
            for (int k = 0; k < exp_addr.size(); k++) begin
                chk({nm, " wb_addr"}, 64'(got_addr[k]), 64'(exp_addr[k]));
                chk({nm, " wb_data"}, 64'(got_data[k] == exp_data[k]), 64'd1);
            end
        end
        chk({nm, " wb_stable"}, 64'(stab_err), 64'd0);
        chk({nm, " dirty_load_sets"}, 64'(dl), 64'(exp_dl));
        chk({nm, " valid_load_sets"}, 64'(vl), 64'(exp_vl));
        chk({nm, " dirty_after"}, 64'(pack_arr(dmem)), 64'(exp_d_after));
        chk({nm, " valid_after"}, 64'(pack_arr(vmem)), 64'(exp_v_after));
        chk({nm, " done_one_cycle"}, 64'(done), 64'd0);
        chk({nm, " start_in_done_ignored"}, 64'(busy), 64'd0);
    endtask

    typedef struct {
        string      nm;
        logic [7:0] v;
        logic [7:0] d;
        int         dly;
        int         exp_wb;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{"all_invalid",   8'h00, 8'h00, 1, 0};
        vecs[1] = '{"set3_dirty",    8'h08, 8'h08, 4, 1};
        vecs[2] = '{"sets0_7_dirty", 8'h81, 8'h81, 2, 2};
        vecs[3] = '{"set2_clean",    8'h04, 8'h00, 1, 0};
        vecs[4] = '{"all_dirty",     8'hFF, 8'hFF, 1, 8};
        vecs[5] = '{"sets1_4_valid", 8'h12, 8'h10, 3, 1};

        rst        = 1'b1;
        start      = 1'b0;
        preload    = 1'b0;
        resp_delay = 1;
        stab_err   = 1'b0;
        pre_v      = '0;
        pre_d      = '0;
        for (int i = 0; i < 8; i++) begin
            tmem[i] = (i == 3) ? 24'hABCDEF : 24'($urandom);
            lmem[i] = (i == 3) ? {32{8'h5A}} : {8{$urandom}};
        end

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst busy", 64'(busy), 64'd0);
        chk("rst done", 64'(done), 64'd0);
        chk("rst arr_read", 64'(arr_read), 64'd0);
        chk("rst dirty_load", 64'(dirty_load), 64'd0);
        chk("rst valid_load", 64'(valid_load), 64'd0);
        chk("rst pmem_write", 64'(pmem_write), 64'd0);
        chk("rst wb_count", 64'(wb_count), 64'd0);
        chk("rst pmem_address", 64'(pmem_address), 64'd0);
        chk("rst pmem_wdata", 64'(pmem_wdata == '0), 64'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed table
        for (int k = 0; k < 6; k++) begin
            run_flush(vecs[k].nm, vecs[k].v, vecs[k].d, vecs[k].dly, vecs[k].exp_wb, 0);
            if (k == 1) begin
                chk("set3 address", 64'(got_addr.size() > 0 ? got_addr[0] : 32'h0), 64'hABCDEF60);
                chk("set3 data", 64'(got_data.size() > 0 && got_data[0] == {32{8'h5A}}), 64'd1);
            end
        end

        // start while busy: sets 0 and 6 dirty, extra start after the first write-back
        run_flush("restart_ignored", 8'h41, 8'h41, 3, 2, 6);

        // rst during WB with pmem_write high (responder never answers first)
        preload_arrays(8'h20, 8'h20);
        resp_delay = 1000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 50 && !pmem_write; c++) @(negedge clk);
        chk("rstwb reached_wb", 64'(pmem_write), 64'd1);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstwb busy", 64'(busy), 64'd0);
        chk("rstwb pmem_write", 64'(pmem_write), 64'd0);
        chk("rstwb wb_count", 64'(wb_count), 64'd0);
        chk("rstwb pmem_address", 64'(pmem_address), 64'd0);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("rstwb idle_after", 64'(busy | done | arr_read), 64'd0);
        chk("rstwb dirty5_kept", 64'(dmem[5]), 64'd1);

        // Randomized flushes against the reference model
        for (int r = 0; r < 16; r++) begin
            logic [7:0] rv, rd;
            rv = 8'($urandom);
            rd = 8'($urandom);
            for (int i = 0; i < 8; i++) begin
                tmem[i] = 24'($urandom);
                lmem[i] = {8{$urandom}};
            end
            run_flush("random", rv, rd, int'($urandom_range(1, 5)), $countones(rv & rd),
                      int'($urandom_range(0, 3)) == 0 ? int'($urandom_range(1, 10)) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
